// File: rtl/div_iter_unit_if.sv
// Handshake bundle between the EX-stage divider and the pipeline control/HI-LO path.
`timescale 1ns/1ps
interface div_iter_unit_if #(
  parameter int WIDTH = 32
);
  logic                 start_i;
  logic                 signed_i;
  logic [WIDTH-1:0]     opa_i;
  logic [WIDTH-1:0]     opb_i;
  logic                 annul_i;
  logic                 advance_i;
  logic                 stall_o;
  logic                 ready_o;
  logic [2*WIDTH-1:0]   result_o;

  modport master (
    output start_i, signed_i, opa_i, opb_i, annul_i, advance_i,
    input  stall_o, ready_o, result_o
  );

  modport slave (
    input  start_i, signed_i, opa_i, opb_i, annul_i, advance_i,
    output stall_o, ready_o, result_o
  );
endinterface

// File: rtl/div_iter_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result is {remainder, quotient}.
// Optional DIV_EARLY_EXIT_EN: finish in one cycle when |dividend| < |divisor|.
`timescale 1ns/1ps
module div_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  div_iter_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_dvd;
  logic [WIDTH-1:0]     r_dsr;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_ready;
  logic [2*WIDTH-1:0]   r_result;

  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [WIDTH-1:0]     w_fast_q;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_trial;
  logic [WIDTH-1:0]     w_rem_nxt;
  logic [WIDTH-1:0]     w_quo_nxt;
  logic                 w_qbit;
  logic                 w_last;
  logic                 w_zero;
  logic                 w_early;
  logic                 w_go;

  function automatic logic [WIDTH-1:0] abs_op(input logic [WIDTH-1:0] v, input logic sg);
    return (sg && v[WIDTH-1]) ? (~v + ONE) : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + ONE) : v;
  endfunction

  assign w_abs_a  = abs_op(bus.opa_i, bus.signed_i);
  assign w_abs_b  = abs_op(bus.opb_i, bus.signed_i);
  assign w_zero   = (bus.opb_i == '0);
  assign w_go     = bus.start_i & ~bus.annul_i;
  // Divide-by-zero yields all-ones quotient; early exit yields zero quotient.
  assign w_fast_q = {WIDTH{w_zero}};

`ifdef DIV_EARLY_EXIT_EN
  assign w_early = ~w_zero & (w_abs_a < w_abs_b);
`else
  assign w_early = 1'b0;
`endif

  assign w_rem_sh  = {r_rem, r_dvd[WIDTH-1]};
  assign w_trial   = w_rem_sh - {1'b0, r_dsr};
  assign w_qbit    = ~w_trial[WIDTH];
  assign w_rem_nxt = w_qbit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_quo_nxt = {r_dvd[WIDTH-2:0], w_qbit};
  assign w_last    = (r_cnt == CNT_W'(WIDTH-1));

  always_comb begin
    w_state_nxt = r_state;
    if (bus.annul_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start_i) w_state_nxt = (w_zero || w_early) ? S_DONE : S_BUSY;
        S_BUSY: begin
          if (!bus.start_i)  w_state_nxt = S_IDLE;
          else if (w_last)   w_state_nxt = S_DONE;
        end
        S_DONE: if (bus.advance_i) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_go) begin
          r_cnt <= '0;
          if (w_zero || w_early) begin
            r_result <= {bus.opa_i, w_fast_q};
          end else begin
            r_rem   <= '0;
            r_dvd   <= w_abs_a;
            r_dsr   <= w_abs_b;
            r_neg_q <= bus.signed_i & (bus.opa_i[WIDTH-1] ^ bus.opb_i[WIDTH-1]);
            r_neg_r <= bus.signed_i & bus.opa_i[WIDTH-1];
          end
        end
        // One quotient bit per cycle; sign fix-up folds into the final iteration.
        S_BUSY: if (w_go) begin
          r_rem <= w_rem_nxt;
          r_dvd <= w_quo_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) r_result <= {neg_if(w_rem_nxt, r_neg_r), neg_if(w_quo_nxt, r_neg_q)};
        end
        default: ;
      endcase
    end
  end

  assign bus.stall_o  = bus.start_i & ~bus.annul_i & (r_state != S_DONE);
  assign bus.ready_o  = r_ready;
  assign bus.result_o = r_result;
endmodule

// File: tb/tb_div_iter_unit.sv
// Directed scoreboard bench for div_iter_unit: latency, stall, annul, hold, reset, arithmetic.
`timescale 1ns/1ps
module tb_div_iter_unit;
`ifdef DIV_EARLY_EXIT_EN
  localparam int EE_STALL = 1;
`else
  localparam int EE_STALL = 33;
`endif

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  logic [63:0] sb_q[$];
  logic [63:0] last_res;

  div_iter_unit_if #(.WIDTH(32)) bus ();
  div_iter_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_div(input string tag, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, input int exp_stall, input logic adv);
    logic [63:0] exp_res;
    int stalls;
    int cyc;
    sb_q.push_back(model(sg, a, b));
    @(negedge clk);
    bus.start_i = 1'b1; bus.signed_i = sg; bus.opa_i = a; bus.opb_i = b;
    bus.advance_i = 1'b0; bus.annul_i = 1'b0;
    #1;
    stalls = 0;
    cyc = 0;
    while (!bus.ready_o && cyc < 200) begin
      if (bus.stall_o) stalls++;
      @(negedge clk); #1;
      cyc++;
    end
    chk({tag, "_ready"}, 64'(bus.ready_o), 64'd1);
    chk({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_stall));
    chk({tag, "_stall_in_done"}, 64'(bus.stall_o), 64'd0);
    if (sb_q.size() > 0) begin
      exp_res = sb_q.pop_front();
      chk({tag, "_result"}, bus.result_o, exp_res);
      last_res = exp_res;
    end
    if (adv) begin
      bus.advance_i = 1'b1;
      @(negedge clk); #1;
      chk({tag, "_ready_after_adv"}, 64'(bus.ready_o), 64'd0);
      chk({tag, "_stall_idle_after_adv"}, 64'(bus.stall_o), 64'd1);
      bus.start_i = 1'b0;
      bus.advance_i = 1'b0;
    end
  endtask

  initial begin
    int hi_cnt;
    n_pass = 0; n_total = 0; last_res = '0;
    rst = 1'b1;
    bus.start_i = 1'b0; bus.signed_i = 1'b0; bus.opa_i = '0; bus.opb_i = '0;
    bus.annul_i = 1'b0; bus.advance_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_result", bus.result_o, 64'd0);
    chk("rst_stall", 64'(bus.stall_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // T1..T3: arithmetic and latency
    do_div("t1_divu_100_7", 1'b0, 32'd100, 32'd7, 33, 1'b1);
    do_div("t2_div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 1'b1);
    do_div("t2_div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 1'b1);
    do_div("t3_div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 1'b1);
    do_div("t3_divu_5_0", 1'b0, 32'd5, 32'd0, 1, 1'b1);
    do_div("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, 1'b1);
    do_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h0001_0003, 33, 1'b1);

    // T4: annul mid-BUSY discards the divide
    @(negedge clk);
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.opa_i = 32'd1000; bus.opb_i = 32'd3;
    repeat (10) @(negedge clk);
    bus.annul_i = 1'b1;
    #1;
    chk("t4_stall_during_annul", 64'(bus.stall_o), 64'd0);
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    #1;
    chk("t4_ready_after_annul", 64'(bus.ready_o), 64'd0);
    hi_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (bus.ready_o) hi_cnt++;
    end
    chk("t4_ready_never", 64'(hi_cnt), 64'd0);
    chk("t4_result_kept", bus.result_o, last_res);
    do_div("t4_divu_9_3", 1'b0, 32'd9, 32'd3, 33, 1'b1);

    // T5: hold in DONE while advance_i is low
    do_div("t5_hold", 1'b0, 32'd1234567, 32'd89, 33, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("t5_hold_result", bus.result_o, last_res);
      chk("t5_hold_stall", 64'(bus.stall_o), 64'd0);
      chk("t5_hold_ready", 64'(bus.ready_o), 64'd1);
    end
    bus.advance_i = 1'b1;
    @(negedge clk); #1;
    chk("t5_ready_after_adv", 64'(bus.ready_o), 64'd0);
    bus.advance_i = 1'b0;
    bus.start_i = 1'b0;

    // T5: asynchronous reset mid-BUSY
    @(negedge clk);
    bus.start_i = 1'b1; bus.signed_i = 1'b1; bus.opa_i = 32'd77; bus.opb_i = 32'd5;
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b1;
    bus.start_i = 1'b0;
    #1;
    chk("t5_rst_ready", 64'(bus.ready_o), 64'd0);
    chk("t5_rst_result", bus.result_o, 64'd0);
    chk("t5_rst_stall", 64'(bus.stall_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // T6: small dividend, early-exit build dependent latency
    do_div("t6_divu_3_10", 1'b0, 32'd3, 32'd10, EE_STALL, 1'b1);
    do_div("t6_div_m3_10", 1'b1, 32'hFFFF_FFFD, 32'd10, EE_STALL, 1'b1);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
